qa_csr_bank: RTL and testbench
==============================

# qa_csr_bank

Parametrised host CSR write decoder for the QA driver: turns the FIU configuration-write stream into a bank of atomically updated 64-bit address registers, a 32-bit control register, and buffered command channels with valid/ready handshakes. It sits between the FIU snoop path and AFU consumers. It replaces fixed per-register decode and single-cycle pulses, which a busy consumer can miss, with depth-configurable command FIFOs and overflow reporting.

## Interface
- N_ADDR_REGS, 4: number of 64-bit address registers.
- N_CMD, 2: number of command channels.
- CMD_FIFO_DEPTH, 4: entries per command FIFO; power of two, ≥2.
- CMD_WIDTH, 32: command payload bits, ≤32, taken from cfg_data[CMD_WIDTH-1:0].
- CSR_BASE, 14'h0A00: word address of the first bank register.
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  CSR write strobe (FIU c0Rx cfgValid).
- cfg_addr  in  14  CSR word address (byte address >> 2).
- cfg_data  in  32  CSR write data.
- addr_reg  out  64*N_ADDR_REGS  committed address registers; register i is bits [64i+63:64i].
- addr_valid  out  N_ADDR_REGS  sticky flag: register i has been committed at least once.
- addr_update  out  N_ADDR_REGS  one-cycle pulse on each commit.
- ctrl  out  32  control register.
- cmd_valid  out  N_CMD  channel j has data.
- cmd_data  out  CMD_WIDTH*N_CMD  head entry of channel j (show-ahead).
- cmd_ready  in  N_CMD  consumer pops channel j when cmd_valid[j] & cmd_ready[j].
- cmd_overflow  out  N_CMD  sticky flag: a write to channel j was dropped.

## Operation
- Address map, relative to CSR_BASE:
  - 2i: LOW of register i.
  - 2i+1: HIGH of register i.
  - 2N_ADDR_REGS+j: command channel j.
  - 2N_ADDR_REGS+N_CMD: ctrl.
  - 2N_ADDR_REGS+N_CMD+1: overflow clear.
  - All other addresses are ignored, with no side effects.
- LOW write stores cfg_data in staging register i only. addr_reg is unchanged.
- HIGH write commits addr_reg[i] <= {cfg_data, staging[i]}, sets addr_valid[i] and pulses addr_update[i].
  - A HIGH write with no preceding LOW uses the current staging value. Staging resets to 0.
  - Repeated HIGH writes each commit and each pulse.
- ctrl write replaces all 32 bits.
- Command write pushes cfg_data[CMD_WIDTH-1:0] into FIFO j.
  - Push is accepted when the FIFO is not full, or when it is full and is popped in the same cycle.
  - Otherwise the push is dropped, cmd_overflow[j] is set and FIFO contents are unchanged.
- Overflow-clear write clears cmd_overflow[j] for every j with cfg_data[j]=1.
  - If an overflow occurs in the same cycle as its clear, the set wins.
- FIFO pointers wrap modulo CMD_FIFO_DEPTH. Occupancy is tracked with a counter of width clog2(DEPTH)+1.
- Simultaneous push and pop when the FIFO is empty: the pop is not possible (cmd_valid=0), so the push is accepted.

## Timing
- Reset (asynchronous, immediate): every output is 0. Staging is 0. All FIFOs are empty.
- Reset asserted mid-operation discards all FIFO contents and all committed registers.
- All outputs are registered. Every CSR write takes effect on the edge that samples cfg_valid, so it is visible the next cycle.
- addr_update is high for exactly the cycle after the HIGH write.
- Command latency: a push into an empty FIFO raises cmd_valid the following cycle, with cmd_data = pushed value.
- A pop advances cmd_data to the next entry, or drops cmd_valid, in the following cycle.
- cmd_data is stable while cmd_valid & ~cmd_ready.
- Back-to-back cfg_valid every cycle is supported with no stalls. There is no backpressure to the FIU.

## Structure
- Package qa_csr_bank_pkg holds:
  - t_csr_word_addr (14 bits).
  - Offset functions csr_lo_addr(i), csr_hi_addr(i), csr_cmd_addr(j), csr_ctrl_addr, csr_ovf_clr_addr, all parametrised by N_ADDR_REGS and N_CMD.
  - The default CSR_BASE constant.
- Sub-module qa_csr_cmd_fifo, parametrised by WIDTH and DEPTH:
  - Ports: enq_en, enq_data, deq_en, notFull, notEmpty, first, overflow.
  - Instantiated N_CMD times with a generate loop.

## Test plan
- Reset check: assert reset_n=0 mid-stream → all outputs 0 immediately. After release, cmd_valid=0 and addr_valid=0.
- Atomic commit:
  - Write LOW(1)=0xDEADBEEF → addr_reg[1] unchanged.
  - Then write HIGH(1)=0x00000012 → next cycle addr_reg[1]=0x00000012DEADBEEF, addr_valid[1]=1, addr_update[1] pulse lasting 1 cycle.
- HIGH-only write: write HIGH(0)=0x5 after reset → addr_reg[0]=0x0000000500000000.
- FIFO fill with cmd_ready=0, DEPTH=4:
  - Push 1,2,3,4,5 to channel 0 → cmd_overflow[0]=1.
  - Then pop four entries → data seen in order 1,2,3,4, and 5 is absent.
- Full plus simultaneous pop: FIFO full, push 9 with cmd_ready=1 → accepted, no overflow, 9 emerges fourth.
- Overflow clear and unmapped addresses:
  - Clear bit0 → cmd_overflow[0]=0.
  - Write to CSR_BASE+0x100 → no output changes.
  - Back-to-back ctrl writes 0xA then 0xB → ctrl=0xB one cycle after the second write.

Source files
------------

// File: rtl/qa_csr_bank_pkg.sv
// qa_csr_bank shared types and CSR offset map.
// Offsets are relative to the bank base word address.
package qa_csr_bank_pkg;

  typedef logic [13:0] t_csr_word_addr;

  localparam t_csr_word_addr CSR_BASE_DEFAULT = 14'h0A00;

  function automatic t_csr_word_addr csr_lo_addr(input int i);
    return t_csr_word_addr'(2 * i);
  endfunction

  function automatic t_csr_word_addr csr_hi_addr(input int i);
    return t_csr_word_addr'(2 * i + 1);
  endfunction

  function automatic t_csr_word_addr csr_cmd_addr(
    input int n_addr,
    input int j
  );
    return t_csr_word_addr'(2 * n_addr + j);
  endfunction

  function automatic t_csr_word_addr csr_ctrl_addr(
    input int n_addr,
    input int n_cmd
  );
    return t_csr_word_addr'(2 * n_addr + n_cmd);
  endfunction

  function automatic t_csr_word_addr csr_ovf_clr_addr(
    input int n_addr,
    input int n_cmd
  );
    return t_csr_word_addr'(2 * n_addr + n_cmd + 1);
  endfunction

endpackage

// File: rtl/qa_csr_bank_cmd_fifo.sv
// qa_csr_cmd_fifo: show-ahead command FIFO.
// A push into a full FIFO is kept only if a pop frees a slot that cycle.
import qa_csr_bank_pkg::*;

module qa_csr_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq_en,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq_en,
  output logic             notFull,
  output logic             notEmpty,
  output logic [WIDTH-1:0] first,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             deq;
  logic             enq;

  assign notFull  = cnt_q != CW'(DEPTH);
  assign notEmpty = cnt_q != '0;
  assign first    = mem_q[rd_q];
  assign deq      = deq_en & notEmpty;
  assign enq      = enq_en & (notFull | deq);
  assign overflow = enq_en & ~enq;

  // storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq) begin
        mem_q[wr_q] <= enq_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (deq) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(enq) - CW'(deq);
    end
  end

endmodule

// File: rtl/qa_csr_bank.sv
// qa_csr_bank: host CSR write decoder with atomic 64-bit
// address registers, control register and command FIFOs.
import qa_csr_bank_pkg::*;

module qa_csr_bank #(
  parameter int             N_ADDR_REGS    = 4,
  parameter int             N_CMD          = 2,
  parameter int             CMD_FIFO_DEPTH = 4,
  parameter int             CMD_WIDTH      = 32,
  parameter t_csr_word_addr CSR_BASE       = CSR_BASE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_valid,
  input  logic [13:0]                   cfg_addr,
  input  logic [31:0]                   cfg_data,
  output logic [64*N_ADDR_REGS-1:0]     addr_reg,
  output logic [N_ADDR_REGS-1:0]        addr_valid,
  output logic [N_ADDR_REGS-1:0]        addr_update,
  output logic [31:0]                   ctrl,
  output logic [N_CMD-1:0]              cmd_valid,
  output logic [CMD_WIDTH*N_CMD-1:0]    cmd_data,
  input  logic [N_CMD-1:0]              cmd_ready,
  output logic [N_CMD-1:0]              cmd_overflow
);

  localparam int NA = N_ADDR_REGS;
  localparam int NC = N_CMD;

  t_csr_word_addr         off;
  logic [NA-1:0]          lo_we;
  logic [NA-1:0]          hi_we;
  logic [NC-1:0]          cmd_we;
  logic                   ctrl_we;
  logic                   clr_we;
  logic [NC-1:0]          clr_mask;
  logic [NC-1:0]          drop;
  logic [NC-1:0]          notfull_unused;

  logic [NA-1:0][31:0]    stg_q;
  logic [NA-1:0][63:0]    addr_q;
  logic [NA-1:0]          av_q;
  logic [NA-1:0]          upd_q;
  logic [31:0]            ctrl_q;
  logic [NC-1:0]          ovf_q;

  // addresses below the base wrap far above the map
  assign off = cfg_addr - CSR_BASE;

  // one-hot write-enable decode of the bank offset
  always_comb begin
    lo_we   = '0;
    hi_we   = '0;
    cmd_we  = '0;
    ctrl_we = 1'b0;
    clr_we  = 1'b0;
    if (cfg_valid) begin
      for (int i = 0; i < NA; i++) begin
        lo_we[i] = off == csr_lo_addr(i);
        hi_we[i] = off == csr_hi_addr(i);
      end
      for (int j = 0; j < NC; j++)
        cmd_we[j] = off == csr_cmd_addr(NA, j);
      ctrl_we = off == csr_ctrl_addr(NA, NC);
      clr_we  = off == csr_ovf_clr_addr(NA, NC);
    end
  end

  assign clr_mask = clr_we ? cfg_data[NC-1:0] : '0;

  // staging, atomic commit, ctrl and sticky overflow state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_q  <= '0;
      addr_q <= '0;
      av_q   <= '0;
      upd_q  <= '0;
      ctrl_q <= '0;
      ovf_q  <= '0;
    end else begin
      upd_q <= hi_we;
      av_q  <= av_q | hi_we;
      for (int i = 0; i < NA; i++) begin
        if (lo_we[i]) stg_q[i]  <= cfg_data;
        if (hi_we[i]) addr_q[i] <= {cfg_data, stg_q[i]};
      end
      if (ctrl_we) ctrl_q <= cfg_data;
      ovf_q <= (ovf_q & ~clr_mask) | drop;
    end
  end

  for (genvar j = 0; j < NC; j++) begin : g_cmd
    qa_csr_cmd_fifo #(
      .WIDTH (CMD_WIDTH),
      .DEPTH (CMD_FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .enq_en   (cmd_we[j]),
      .enq_data (cfg_data[CMD_WIDTH-1:0]),
      .deq_en   (cmd_ready[j]),
      .notFull  (notfull_unused[j]),
      .notEmpty (cmd_valid[j]),
      .first    (cmd_data[j*CMD_WIDTH +: CMD_WIDTH]),
      .overflow (drop[j])
    );
  end

  assign addr_reg     = addr_q;
  assign addr_valid   = av_q;
  assign addr_update  = upd_q;
  assign ctrl         = ctrl_q;
  assign cmd_overflow = ovf_q;

endmodule

// File: tb/tb_qa_csr_bank.sv
// Scoreboard bench for qa_csr_bank: random and directed CSR
// writes against a behavioural model of the register bank.
module tb_qa_csr_bank;

  localparam int NA  = 4;
  localparam int NC  = 2;
  localparam int DEP = 4;
  localparam int CW  = 32;
  localparam logic [13:0] BASE = 14'h0A00;
  localparam int A_CMD  = 2 * NA;
  localparam int A_CTRL = 2 * NA + NC;
  localparam int A_CLR  = 2 * NA + NC + 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic [13:0]          cfg_addr = '0;
  logic [31:0]          cfg_data = '0;
  logic [64*NA-1:0]     addr_reg;
  logic [NA-1:0]        addr_valid;
  logic [NA-1:0]        addr_update;
  logic [31:0]          ctrl;
  logic [NC-1:0]        cmd_valid;
  logic [CW*NC-1:0]     cmd_data;
  logic [NC-1:0]        cmd_ready = '0;
  logic [NC-1:0]        cmd_overflow;

  qa_csr_bank dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .addr_reg     (addr_reg),
    .addr_valid   (addr_valid),
    .addr_update  (addr_update),
    .ctrl         (ctrl),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .cmd_overflow (cmd_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NA-1:0][63:0] addr;
    logic [NA-1:0][31:0] stg;
    logic [NA-1:0]       av;
    logic [NA-1:0]       upd;
    logic [31:0]         ctrl;
    logic [NC-1:0]       ovf;
    logic [NC-1:0][3:0]  cnt;
  } mstate_t;

  // S: state after all scheduled edges; V: state the DUT shows now
  mstate_t S = '0;
  mstate_t V = '0;
  logic [31:0] expq [NC][$];
  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs and advance the model for its edge
  task automatic cyc(bit v, logic [13:0] a, logic [31:0] d,
                     logic [NC-1:0] rdy);
    int off;
    logic [NC-1:0] pop;
    logic [NC-1:0] push;
    logic [NC-1:0] drop;
    logic [NC-1:0] clr;
    @(posedge clk);
    #1;
    V = S;
    S.upd = '0;
    cfg_valid = v;
    cfg_addr  = a;
    cfg_data  = d;
    cmd_ready = rdy;
    pop = '0; push = '0; drop = '0; clr = '0;
    for (int j = 0; j < NC; j++) pop[j] = rdy[j] && S.cnt[j] != 0;
    off = int'(a) - int'(BASE);
    if (v && off >= 0) begin
      if (off < 2 * NA) begin
        if (off % 2 == 0) S.stg[off / 2] = d;
        else begin
          S.addr[off / 2] = {d, S.stg[off / 2]};
          S.av[off / 2]   = 1'b1;
          S.upd[off / 2]  = 1'b1;
        end
      end else if (off < A_CTRL) begin
        if (S.cnt[off - A_CMD] < DEP || pop[off - A_CMD]) begin
          push[off - A_CMD] = 1'b1;
          expq[off - A_CMD].push_back(d);
        end else drop[off - A_CMD] = 1'b1;
      end else if (off == A_CTRL) S.ctrl = d;
      else if (off == A_CLR) clr = d[NC-1:0];
    end
    for (int j = 0; j < NC; j++)
      S.cnt[j] = S.cnt[j] + 4'(push[j]) - 4'(pop[j]);
    S.ovf = (S.ovf & ~clr) | drop;
  endtask

  task automatic idle(logic [NC-1:0] rdy);
    cyc(1'b0, '0, '0, rdy);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_addr_reg"}, 64'(|addr_reg), 64'd0);
    check({tag, "_addr_valid"}, 64'(addr_valid), 64'd0);
    check({tag, "_addr_update"}, 64'(addr_update), 64'd0);
    check({tag, "_ctrl"}, 64'(ctrl), 64'd0);
    check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, "_cmd_data"}, 64'(|cmd_data), 64'd0);
    check({tag, "_cmd_overflow"}, 64'(cmd_overflow), 64'd0);
  endtask

  // monitor: compare visible state, pop scoreboard on handshakes
  always @(negedge clk) begin
    if (reset_n) begin
      check("ctrl", 64'(ctrl), 64'(V.ctrl));
      check("addr_valid", 64'(addr_valid), 64'(V.av));
      check("addr_update", 64'(addr_update), 64'(V.upd));
      check("cmd_overflow", 64'(cmd_overflow), 64'(V.ovf));
      for (int i = 0; i < NA; i++)
        check($sformatf("addr_reg%0d", i), addr_reg[64*i +: 64],
              V.addr[i]);
      for (int j = 0; j < NC; j++) begin
        check($sformatf("cmd_valid%0d", j), 64'(cmd_valid[j]),
              64'(V.cnt[j] != 0));
        if (cmd_valid[j]) begin
          if (expq[j].size() == 0) begin
            total++;
            bad++;
            $display("FAIL cmd_data%0d got=%h want=<empty>", j,
                     cmd_data[CW*j +: CW]);
          end else begin
            check($sformatf("cmd_data%0d", j),
                  64'(cmd_data[CW*j +: CW]), 64'(expq[j][0]));
            if (cmd_ready[j]) void'(expq[j].pop_front());
          end
        end
      end
    end
  end

  task automatic rand_phase(int n);
    logic [13:0] a;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 9) == 0) a = 14'($urandom);
      else a = BASE + 14'($urandom_range(0, A_CLR + 1));
      cyc(1'($urandom_range(0, 3) != 0), a, $urandom,
          NC'($urandom));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    reset_n = 1'b1;

    // HIGH-only commit uses the reset staging value
    cyc(1'b1, BASE + 14'd1, 32'h5, '0);
    idle('0);
    check("hi_only", addr_reg[63:0], 64'h0000_0005_0000_0000);

    // LOW alone leaves the register, HIGH commits both halves
    cyc(1'b1, BASE + 14'd2, 32'hDEADBEEF, '0);
    idle('0);
    check("lo_hold", addr_reg[127:64], 64'd0);
    cyc(1'b1, BASE + 14'd3, 32'h12, '0);
    idle('0);
    check("commit", addr_reg[127:64], 64'h0000_0012_DEAD_BEEF);
    check("upd_on", 64'(addr_update[1]), 64'd1);
    idle('0);
    check("upd_off", 64'(addr_update[1]), 64'd0);

    // overfill channel 0, then drain 1..4 in order
    for (int k = 1; k <= 5; k++)
      cyc(1'b1, BASE + 14'(A_CMD), 32'(k), '0);
    idle('0);
    check("ovf_set", 64'(cmd_overflow[0]), 64'd1);
    repeat (4) idle(2'b01);
    idle('0);
    check("drained", 64'(cmd_valid[0]), 64'd0);

    // overflow clear and an unmapped write
    cyc(1'b1, BASE + 14'(A_CLR), 32'h1, '0);
    cyc(1'b1, BASE + 14'h100, 32'hFFFF_FFFF, '0);
    idle('0);
    check("ovf_clr", 64'(cmd_overflow[0]), 64'd0);

    // push into a full FIFO while it pops
    for (int k = 5; k <= 8; k++)
      cyc(1'b1, BASE + 14'(A_CMD), 32'(k), '0);
    cyc(1'b1, BASE + 14'(A_CMD), 32'd9, 2'b01);
    idle('0);
    check("full_pop_ovf", 64'(cmd_overflow[0]), 64'd0);
    repeat (5) idle(2'b01);

    // back-to-back ctrl writes
    cyc(1'b1, BASE + 14'(A_CTRL), 32'hA, '0);
    cyc(1'b1, BASE + 14'(A_CTRL), 32'hB, '0);
    idle('0);
    check("ctrl_b2b", 64'(ctrl), 64'hB);

    rand_phase(400);

    // asynchronous reset in the middle of traffic
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    S = '0;
    V = '0;
    for (int j = 0; j < NC; j++) expq[j].delete();
    cfg_valid = 1'b0;
    cmd_ready = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    rand_phase(300);
    repeat (2 * DEP + 2) idle('1);
    idle('0);
    for (int j = 0; j < NC; j++)
      check($sformatf("drain%0d", j), 64'(expq[j].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
